// File: rtl/lap_stopwatch_pkg.sv
// Shared types for the lap stopwatch: BCD time word, digit limits, FSM states,
// segment patterns and the ripple-carry BCD increment.
package lap_stopwatch_pkg;

    // Index 0 is centiseconds units, index 5 is minutes tens.
    typedef logic [5:0][3:0] bcd_time_t;

    localparam bcd_time_t DIGIT_LIMIT = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Active-low gfedcba patterns for 0..9.
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bcd_time_t bcd_increment(input bcd_time_t t);
        bcd_time_t r;
        logic      carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r[i] == DIGIT_LIMIT[i]) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = r[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_stopwatch_lap_buffer.sv
// Circular lap store: write pointer, saturating valid count, and read of the
// k-th most recent entry.
module lap_stopwatch_lap_buffer
    import lap_stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               wr_en,
    input  bcd_time_t                          wr_data,
    input  logic [$clog2(LAP_DEPTH+1)-1:0]     rd_idx,
    output bcd_time_t                          rd_data,
    output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count
);

    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int SW = CW + 1;

    bcd_time_t       mem [LAP_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [SW-1:0]   rd_sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr    <= '0;
            lap_count <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == PW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (lap_count != CW'(LAP_DEPTH)) lap_count <= lap_count + CW'(1);
        end
    end

    // Lap contents need no reset: lap_count marks which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // (wr_ptr - k) mod LAP_DEPTH, kept non-negative by adding LAP_DEPTH first.
    always_comb begin
        rd_sum = SW'(wr_ptr) + SW'(LAP_DEPTH) - SW'(rd_idx);
        if (rd_sum >= SW'(LAP_DEPTH)) rd_sum = rd_sum - SW'(LAP_DEPTH);
    end

    assign rd_data = mem[PW'(rd_sum)];

endmodule

// File: rtl/seven_segment_converter.sv
// One BCD digit to active-low seven-segment pattern; codes above 9 blank the digit.
module seven_segment_converter
    import lap_stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) seg = SEG_DIGIT[digit];
    end

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS.cc stopwatch with start/stop, lap memory and a view selector driving
// six active-low HEX displays.
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4,
    parameter int DEB_LEN   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ssr,
    input  logic                           lap,
    input  logic                           view,
    output logic [6:0]                     HEX0,
    output logic [6:0]                     HEX1,
    output logic [6:0]                     HEX2,
    output logic [6:0]                     HEX3,
    output logic [6:0]                     HEX4,
    output logic [6:0]                     HEX5,
    output logic                           running,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic [$clog2(LAP_DEPTH+1)-1:0] view_idx
);

    localparam int CW    = $clog2(LAP_DEPTH + 1);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DEB_LEN-1:0] PRESS_PAT = {{(DEB_LEN/2){1'b0}}, {(DEB_LEN/2){1'b1}}};

    logic [DEB_LEN-1:0] ssr_hist, lap_hist, view_hist;
    logic               ssr_ev, lap_ev, view_ev;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    state_t             state, state_nx;
    logic               clear, lap_wr, view_step, count_en;
    bcd_time_t          cur_time, lap_time, shown;

    // Newest sample enters at bit 0; a press is zeros (older) then ones (newer).
    always_ff @(posedge clk) begin
        if (rst) begin
            ssr_hist  <= '1;
            lap_hist  <= '1;
            view_hist <= '1;
        end else begin
            ssr_hist  <= {ssr_hist[DEB_LEN-2:0], ssr};
            lap_hist  <= {lap_hist[DEB_LEN-2:0], lap};
            view_hist <= {view_hist[DEB_LEN-2:0], view};
        end
    end

    assign ssr_ev  = (ssr_hist == PRESS_PAT);
    assign lap_ev  = (lap_hist == PRESS_PAT);
    assign view_ev = (view_hist == PRESS_PAT);

    assign tick = (tick_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) tick_cnt <= '0;
        else if (tick)    tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == ST_RUN);
        end
    end

    // Priority ssr > lap > view; a tick in RUN still counts on the stopping edge.
    always_comb begin
        state_nx  = state;
        clear     = 1'b0;
        lap_wr    = 1'b0;
        view_step = 1'b0;
        count_en  = (state == ST_RUN) && tick;
        if (ssr_ev) begin
            case (state)
                ST_RUN:  state_nx = ST_STOP;
                default: state_nx = ST_RUN;
            endcase
        end else if (lap_ev) begin
            case (state)
                ST_RUN:  lap_wr = 1'b1;
                ST_STOP: begin
                    clear    = 1'b1;
                    state_nx = ST_IDLE;
                end
                default: ;
            endcase
        end else if (view_ev) begin
            view_step = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear)  cur_time <= '0;
        else if (count_en) cur_time <= bcd_increment(cur_time);
    end

    always_ff @(posedge clk) begin
        if (rst || clear || lap_wr) view_idx <= '0;
        else if (view_step)         view_idx <= (view_idx == lap_count) ? '0 : view_idx + CW'(1);
    end

    lap_stopwatch_lap_buffer #(.LAP_DEPTH(LAP_DEPTH)) u_laps (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear),
        .wr_en     (lap_wr),
        .wr_data   (cur_time),
        .rd_idx    (view_idx),
        .rd_data   (lap_time),
        .lap_count (lap_count)
    );

    assign shown = (view_idx == '0) ? cur_time : lap_time;

    seven_segment_converter u_hex0 (.digit(shown[0]), .seg(HEX0));
    seven_segment_converter u_hex1 (.digit(shown[1]), .seg(HEX1));
    seven_segment_converter u_hex2 (.digit(shown[2]), .seg(HEX2));
    seven_segment_converter u_hex3 (.digit(shown[3]), .seg(HEX3));
    seven_segment_converter u_hex4 (.digit(shown[4]), .seg(HEX4));
    seven_segment_converter u_hex5 (.digit(shown[5]), .seg(HEX5));

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: hand tables, timed corner sequences and random
// button activity, all checked every cycle against a centisecond-level model.
module tb_lap_stopwatch;

    localparam int CLK_HZ = 1000;
    localparam int TICK_HZ = 100;
    localparam int DEPTH = 4;
    localparam int DEB = 4;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int WRAP = 360000;
    localparam logic [6:0] TSEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk = 1'b0;
    logic rst = 1'b1, ssr = 1'b0, lap = 1'b0, view = 1'b0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic running;
    logic [2:0] lap_count, view_idx;

    logic f_ssr = 1'b0, f_lap = 1'b0, f_view = 1'b0;
    logic [6:0] F0, F1, F2, F3, F4, F5;
    logic f_running;
    logic [2:0] f_lc, f_vi;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lap_stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .LAP_DEPTH(DEPTH), .DEB_LEN(DEB)) dut (
        .clk(clk), .rst(rst), .ssr(ssr), .lap(lap), .view(view),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .running(running), .lap_count(lap_count), .view_idx(view_idx)
    );

    // Tick every clock, so minute carries are reachable in a short run.
    lap_stopwatch #(.CLK_HZ(100), .TICK_HZ(100), .LAP_DEPTH(DEPTH), .DEB_LEN(DEB)) dut_fast (
        .clk(clk), .rst(rst), .ssr(f_ssr), .lap(f_lap), .view(f_view),
        .HEX0(F0), .HEX1(F1), .HEX2(F2), .HEX3(F3), .HEX4(F4), .HEX5(F5),
        .running(f_running), .lap_count(f_lc), .view_idx(f_vi)
    );

    // ---------------- reference model (time as integer centiseconds) ----------------
    int m_st;        // 0 idle, 1 run, 2 stop
    int m_time;
    int m_laps[$];   // most recent first
    int m_view;
    int m_cnt;
    bit hq_s[$], hq_l[$], hq_v[$];

    function automatic bit is_press(input bit q[$]);
        if (q.size() != DEB) return 1'b0;
        for (int i = 0; i < DEB; i++) begin
            if (q[i] != (i >= DEB / 2)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [41:0] exp_hex(input int v);
        int d[6];
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = (v / 1000) % 6;
        d[4] = (v / 6000) % 10;
        d[5] = (v / 60000) % 6;
        return {TSEG[d[5]], TSEG[d[4]], TSEG[d[3]], TSEG[d[2]], TSEG[d[1]], TSEG[d[0]]};
    endfunction

    function automatic int m_shown();
        if (m_view == 0 || m_view > m_laps.size()) return m_time;
        return m_laps[m_view - 1];
    endfunction

    task automatic model_step(input bit r, input bit s, input bit l, input bit v);
        bit es, el, ev, tk;
        int nt;
        if (r) begin
            m_st = 0; m_time = 0; m_view = 0; m_cnt = 0;
            m_laps.delete();
            hq_s.delete(); hq_l.delete(); hq_v.delete();
            repeat (DEB) begin
                hq_s.push_back(1'b1); hq_l.push_back(1'b1); hq_v.push_back(1'b1);
            end
            return;
        end
        es = is_press(hq_s); el = is_press(hq_l); ev = is_press(hq_v);
        hq_s.push_back(s); hq_l.push_back(l); hq_v.push_back(v);
        while (hq_s.size() > DEB) void'(hq_s.pop_front());
        while (hq_l.size() > DEB) void'(hq_l.pop_front());
        while (hq_v.size() > DEB) void'(hq_v.pop_front());
        tk = (m_cnt == DIV - 1);
        m_cnt = (m_cnt + 1) % DIV;
        nt = (m_st == 1 && tk) ? (m_time + 1) % WRAP : m_time;
        if (es) begin
            m_st = (m_st == 1) ? 2 : 1;
        end else if (el) begin
            if (m_st == 1) begin
                m_laps.push_front(m_time);
                if (m_laps.size() > DEPTH) void'(m_laps.pop_back());
                m_view = 0;
            end else if (m_st == 2) begin
                nt = 0; m_laps.delete(); m_view = 0; m_cnt = 0; m_st = 0;
            end
        end else if (ev) begin
            m_view = (m_view == m_laps.size()) ? 0 : m_view + 1;
        end
        m_time = nt;
    endtask

    function automatic logic [41:0] dut_hex();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic check_model();
        bit ok;
        ok = (running === (m_st == 1)) && (int'(lap_count) == m_laps.size()) &&
             (int'(view_idx) == m_view) && (dut_hex() === exp_hex(m_shown()));
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL model @%0t: got run=%0b laps=%0d view=%0d hex=%h, expected run=%0b laps=%0d view=%0d hex=%h",
                     $time, running, lap_count, view_idx, dut_hex(),
                     (m_st == 1), m_laps.size(), m_view, exp_hex(m_shown()));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(rst, ssr, lap, view);
        #1;
        if (chk_en) check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Event lands on the third edge of the press.
    task automatic press(input bit s, input bit l, input bit v);
        ssr = s; lap = l; view = v;
        repeat (4) cycle();
        ssr = 1'b0; lap = 1'b0; view = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic check_hand(input string name, input bit er, input int elc, input int evi, input int ecs);
        bit ok;
        ok = (running === er) && (int'(lap_count) == elc) && (int'(view_idx) == evi);
        if (ecs >= 0) ok = ok && (dut_hex() === exp_hex(ecs));
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got run=%0b laps=%0d view=%0d hex=%h, expected run=%0b laps=%0d view=%0d cs=%0d hex=%h",
                     name, running, lap_count, view_idx, dut_hex(), er, elc, evi, ecs,
                     (ecs >= 0) ? exp_hex(ecs) : 42'h0);
        end
    endtask

    typedef struct {
        int gap;
        bit s, l, v;
        bit er;
        int elc, evi, ecs;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // After a clear the tick counter is 0, so ticks fall on edges 10, 20, ...
        tbl[0]  = '{0,    1, 0, 0, 1, 0, 0, 1};
        tbl[1]  = '{84,   0, 1, 0, 1, 1, 0, 10};
        tbl[2]  = '{0,    0, 0, 1, 1, 1, 1, 9};
        tbl[3]  = '{0,    0, 0, 1, 1, 1, 0, 12};
        tbl[4]  = '{179,  0, 1, 0, 1, 2, 0, 30};
        tbl[5]  = '{492,  0, 1, 0, 1, 3, 0, 80};
        tbl[6]  = '{1192, 0, 1, 0, 1, 4, 0, 200};
        tbl[7]  = '{992,  0, 1, 0, 1, 4, 0, 300};
        tbl[8]  = '{0,    0, 0, 1, 1, 4, 1, 300};
        tbl[9]  = '{0,    0, 0, 1, 1, 4, 2, 200};
        tbl[10] = '{0,    0, 0, 1, 1, 4, 3, 80};
        tbl[11] = '{0,    0, 0, 1, 1, 4, 4, 30};
        tbl[12] = '{0,    0, 0, 1, 1, 4, 0, 304};
        tbl[13] = '{0,    1, 0, 0, 0, 4, 0, 305};
        tbl[14] = '{0,    0, 0, 1, 0, 4, 1, 300};
        tbl[15] = '{0,    0, 0, 1, 0, 4, 2, 200};
        tbl[16] = '{0,    0, 1, 0, 0, 0, 0, 0};

        rst = 1'b1;
        cycle();
        chk_en = 1'b1;
        check_model();
        check_hand("reset", 1'b0, 0, 0, 0);
        rst = 1'b0;
        idle(4);

        // 1234 ticks between the start edge and the stop edge.
        press(1, 0, 0);
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_running: got %0b expected 1", running);
        end
        idle(12332);
        press(1, 0, 0);
        check_hand("stop_12.34", 1'b0, 0, 0, 1234);
        idle(500);
        check_hand("frozen_12.34", 1'b0, 0, 0, 1234);

        press(0, 1, 0);
        check_hand("clear_from_stop", 1'b0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            idle(tbl[i].gap);
            press(tbl[i].s, tbl[i].l, tbl[i].v);
            check_hand($sformatf("table_%0d", i), tbl[i].er, tbl[i].elc, tbl[i].evi, tbl[i].ecs);
        end

        // Three laps, view 2, then ssr+lap together: stop wins, no lap recorded.
        press(1, 0, 0);
        idle(37);
        press(0, 1, 0);
        idle(21);
        press(0, 1, 0);
        idle(13);
        press(0, 1, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        check_hand("three_laps_view2", 1'b1, 3, 2, -1);
        press(1, 1, 0);
        check_hand("ssr_lap_same_cycle", 1'b0, 3, 2, -1);
        press(0, 1, 0);
        check_hand("clear_lc3_vi2", 1'b0, 0, 0, 0);

        // Reset in the middle of a run and in the middle of a press.
        press(1, 0, 0);
        idle(55);
        press(0, 1, 0);
        idle(17);
        ssr = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        check_hand("rst_mid_run", 1'b0, 0, 0, 0);
        rst = 1'b0;
        ssr = 1'b0;
        idle(4);

        // Fast instance: 6123 ticks from start edge to stop edge gives 01:01.23.
        f_ssr = 1'b1;
        repeat (4) cycle();
        f_ssr = 1'b0;
        repeat (4) cycle();
        idle(6115);
        f_ssr = 1'b1;
        repeat (4) cycle();
        f_ssr = 1'b0;
        repeat (4) cycle();
        n_tests++;
        if ({F5, F4, F3, F2, F1, F0} !== exp_hex(6123) || f_running !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_01:01.23: got hex=%h run=%0b expected hex=%h run=0",
                     {F5, F4, F3, F2, F1, F0}, f_running, exp_hex(6123));
        end

        // Random presses, bounces and occasional resets.
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 19);
            idle($urandom_range(0, 150));
            if (r < 5) press(1, 0, 0);
            else if (r < 10) press(0, 1, 0);
            else if (r < 15) press(0, 0, 1);
            else if (r < 17) press($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else if (r < 19) begin
                repeat (6) begin
                    ssr = $urandom_range(0, 1); lap = $urandom_range(0, 1); view = $urandom_range(0, 1);
                    cycle();
                end
                ssr = 1'b0; lap = 1'b0; view = 1'b0;
                idle(4);
            end else begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                idle(4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
